bram_ptr_streamer: RTL and testbench

Playback engine between the AXI-loaded waveform BRAM and the 512-bit AXIS DAC output port (axis_0). Once enabled by the DAC-control GPIO, it reads BRAM words from the start-pointer GPIO value up to the stop-pointer GPIO value and streams each word as one AXIS beat. Looping is optional. Full AXIS backpressure is handled with a credit-limited skid FIFO, so no beat is lost or duplicated.

---
 rtl/bram_ptr_streamer.sv | 236 +++++++++++++++++++++++
 tb/tb_bram_ptr_streamer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_ptr_streamer.sv
// Waveform playback engine: walks a BRAM word range [start, stop) and streams
// each word as one AXIS beat, optionally looping. A credit counter bounds the
// number of outstanding reads so the skid FIFO can never overflow.
module bram_ptr_streamer #(
    parameter int DATA_W     = 512,
    parameter int ADDR_W     = 12,
    parameter int BYTE_SHIFT = 6,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              enable,
    input  logic              loop_en,
    input  logic [31:0]       start_ptr,
    input  logic [31:0]       stop_ptr,
    output logic              bram_en,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [DATA_W-1:0] bram_dout,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              busy,
    output logic              ptr_err,
    output logic [15:0]       wrap_cnt
);

    localparam int IDX_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t            state_q, state_d;
    logic              en_prev_q, loop_q, issued_q;
    logic [ADDR_W-1:0] s_q, e_q, rd_ptr_q;
    logic [CNT_W-1:0]  pend_q, fifo_cnt_q;
    logic [IDX_W-1:0]  wr_idx_q, rd_idx_q;
    logic [RD_LAT-1:0] pipe_v_q, pipe_t_q;
    logic [DATA_W:0]   fifo_mem [FIFO_DEPTH];
    logic              out_valid_q, out_last_q, ptr_err_q;
    logic [DATA_W-1:0] out_data_q;
    logic [15:0]       wrap_cnt_q;

    logic [ADDR_W-1:0] s_in, e_in;
    logic start_edge, handshake, last_hs, pipe_busy, at_end;
    logic issue, load_ok, flush, start_ok, start_bad, fifo_wr, fifo_rd;
    logic unused_ptr_bits;

    // Byte pointers become word indices; the sub-word and high bits are don't-care.
    assign s_in = start_ptr[BYTE_SHIFT +: ADDR_W];
    assign e_in = stop_ptr[BYTE_SHIFT +: ADDR_W];
    assign unused_ptr_bits = ^{start_ptr[31:BYTE_SHIFT+ADDR_W], start_ptr[BYTE_SHIFT-1:0],
                               stop_ptr[31:BYTE_SHIFT+ADDR_W],  stop_ptr[BYTE_SHIFT-1:0]};

    assign start_edge = enable & ~en_prev_q;
    assign handshake  = out_valid_q & m_axis_tready;
    assign last_hs    = handshake & out_last_q;
    assign pipe_busy  = |pipe_v_q;
    assign at_end     = (rd_ptr_q == e_q - ADDR_W'(1));
    // Returning reads are only kept while running; in DRAIN they are dropped.
    assign fifo_wr    = pipe_v_q[RD_LAT-1] & (state_q == S_RUN);
    assign fifo_rd    = load_ok & (fifo_cnt_q != '0) & (~out_valid_q | m_axis_tready);

    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(FIFO_DEPTH - 1)) ? '0 : i + IDX_W'(1);
    endfunction

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_d   = state_q;
        issue     = 1'b0;
        load_ok   = 1'b0;
        flush     = 1'b0;
        start_ok  = 1'b0;
        start_bad = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    if (e_in <= s_in) begin
                        start_bad = 1'b1;
                    end else begin
                        start_ok = 1'b1;
                        state_d  = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (!enable) begin
                    state_d = S_DRAIN;
                end else begin
                    load_ok = 1'b1;
                    issue   = ~issued_q & (pend_q < CNT_W'(FIFO_DEPTH));
                    if (last_hs & ~loop_q) begin
                        flush   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                // A presented beat must be accepted first; otherwise just let reads land.
                if (out_valid_q ? m_axis_tready : ~pipe_busy) begin
                    flush   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register and enable history for edge detection.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= S_IDLE;
            en_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            en_prev_q <= enable;
        end
    end

    // Latched range, loop mode and the read address walker.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s_q      <= '0;
            e_q      <= '0;
            loop_q   <= 1'b0;
            rd_ptr_q <= '0;
            issued_q <= 1'b0;
        end else if (start_ok) begin
            s_q      <= s_in;
            e_q      <= e_in;
            loop_q   <= loop_en;
            rd_ptr_q <= s_in;
            issued_q <= 1'b0;
        end else if (issue) begin
            if (at_end) begin
                rd_ptr_q <= s_q;
                issued_q <= ~loop_q;
            end else begin
                rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            end
        end
    end

    // Valid/last tags shadowing the BRAM read latency.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pipe_v_q <= '0;
            pipe_t_q <= '0;
        end else begin
            pipe_v_q[0] <= issue & ~flush;
            pipe_t_q[0] <= issue & at_end;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_v_q[i] <= pipe_v_q[i-1] & ~flush;
                pipe_t_q[i] <= pipe_t_q[i-1];
            end
        end
    end

    // Credits: reads in flight plus FIFO occupancy.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pend_q <= '0;
        end else if (flush) begin
            pend_q <= '0;
        end else if (issue & ~fifo_rd) begin
            pend_q <= pend_q + CNT_W'(1);
        end else if (~issue & fifo_rd) begin
            pend_q <= pend_q - CNT_W'(1);
        end
    end

    // Skid FIFO bookkeeping.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
            fifo_cnt_q <= '0;
        end else if (flush) begin
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (fifo_wr) wr_idx_q <= idx_inc(wr_idx_q);
            if (fifo_rd) rd_idx_q <= idx_inc(rd_idx_q);
            if (fifo_wr & ~fifo_rd)      fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
            else if (~fifo_wr & fifo_rd) fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
        end
    end

    // FIFO storage: {last tag, data}; contents need no reset.
    always_ff @(posedge aclk) begin
        if (fifo_wr) fifo_mem[wr_idx_q] <= {pipe_t_q[RD_LAT-1], bram_dout};
    end

    // Registered AXIS output stage fed from the FIFO head.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (fifo_rd) begin
            out_valid_q              <= 1'b1;
            {out_last_q, out_data_q} <= fifo_mem[rd_idx_q];
        end else if (handshake) begin
            out_valid_q <= 1'b0;
        end
    end

    // Sticky pointer error and saturating pass counter.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ptr_err_q  <= 1'b0;
            wrap_cnt_q <= '0;
        end else if (start_ok) begin
            ptr_err_q  <= 1'b0;
            wrap_cnt_q <= '0;
        end else begin
            if (start_bad) ptr_err_q <= 1'b1;
            if (last_hs && wrap_cnt_q != 16'hFFFF) wrap_cnt_q <= wrap_cnt_q + 16'd1;
        end
    end

    assign bram_en       = issue;
    assign bram_addr     = issue ? rd_ptr_q : '0;
    assign m_axis_tdata  = out_data_q;
    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tlast  = out_last_q;
    assign busy          = (state_q != S_IDLE);
    assign ptr_err       = ptr_err_q;
    assign wrap_cnt      = wrap_cnt_q;

endmodule

// File: tb/tb_bram_ptr_streamer.sv
// Bench for bram_ptr_streamer: table-driven runs, hand-written corner sequences
// and randomized ranges, all checked against an arithmetic beat model.
module tb_bram_ptr_streamer;

    localparam int DATA_W = 512;
    localparam int ADDR_W = 12;
    localparam int RD_LAT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              aresetn, enable, loop_en, bram_en;
    logic              m_axis_tvalid, m_axis_tready, m_axis_tlast, busy, ptr_err;
    logic [31:0]       start_ptr, stop_ptr;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_dout, bram_s1, m_axis_tdata;
    logic [15:0]       wrap_cnt;
    logic [DATA_W-1:0] mem [4096];

    int checks   = 0;
    int failures = 0;

    bram_ptr_streamer dut (
        .aclk          (clk),
        .aresetn       (aresetn),
        .enable        (enable),
        .loop_en       (loop_en),
        .start_ptr     (start_ptr),
        .stop_ptr      (stop_ptr),
        .bram_en       (bram_en),
        .bram_addr     (bram_addr),
        .bram_dout     (bram_dout),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy),
        .ptr_err       (ptr_err),
        .wrap_cnt      (wrap_cnt)
    );

    // Two-stage registered BRAM model (read latency 2).
    always @(posedge clk) begin
        bram_s1   <= mem[bram_addr];
        bram_dout <= bram_s1;
    end

    function automatic logic [DATA_W-1:0] pat(input int i);
        logic [31:0] w;
        w = 32'(i) ^ 32'hC0DE_0000;
        return {16{w}};
    endfunction

    task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] sp;
        logic [31:0] ep;
        logic        lp;
        int          rmode;     // 0 ready always, 1 pattern 1,0,0,1, 2 random
        int          nbeats;    // beats to collect when looping
        int          exp_wrap;
        bit          timing;    // check first-beat latency and back-to-back beats
    } vec_t;

    // One playback run. Expected beat k is word s + k%len, last when k%len == len-1.
    task automatic run_vec(input vec_t v);
        int s, e, len, target, k, cyc, first_v, acc_first, acc_last, rphase;
        bit prev_stall;
        logic [DATA_W-1:0] prev_d;
        logic prev_l;
        s = int'((v.sp >> 6) & 32'hFFF);
        e = int'((v.ep >> 6) & 32'hFFF);
        len = e - s;
        target = v.lp ? v.nbeats : len;
        k = 0; cyc = 0; first_v = -1; acc_first = -1; acc_last = -1; rphase = 0;
        prev_stall = 1'b0; prev_d = '0; prev_l = 1'b0;
        start_ptr = v.sp; stop_ptr = v.ep; loop_en = v.lp; enable = 1'b1;
        while (k < target && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 2) begin
                start_ptr = $urandom; stop_ptr = $urandom; loop_en = ~v.lp;
            end
            case (v.rmode)
                0: m_axis_tready = 1'b1;
                1: m_axis_tready = (rphase % 4 == 0) || (rphase % 4 == 3);
                default: m_axis_tready = ($urandom_range(0, 3) != 0);
            endcase
            rphase++;
            if (prev_stall) begin
                chk("hold_valid", DATA_W'(m_axis_tvalid), DATA_W'(1));
                chk("hold_data", m_axis_tdata, prev_d);
                chk("hold_last", DATA_W'(m_axis_tlast), DATA_W'(prev_l));
            end
            if (m_axis_tvalid && first_v < 0) first_v = cyc;
            if (m_axis_tvalid && m_axis_tready) begin
                chk("beat_data", m_axis_tdata, pat(s + k % len));
                chk("beat_last", DATA_W'(m_axis_tlast), DATA_W'((k % len) == len - 1));
                if (acc_first < 0) acc_first = cyc;
                acc_last = cyc;
                k++;
                if (v.lp && k == target) enable = 1'b0;
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_d = m_axis_tdata;
            prev_l = m_axis_tlast;
        end
        chk("beat_count", DATA_W'(k), DATA_W'(target));
        if (v.timing) begin
            chk("first_latency", DATA_W'(first_v), DATA_W'(RD_LAT + 3));
            chk("back_to_back", DATA_W'(acc_last - acc_first), DATA_W'(target - 1));
        end
        @(negedge clk);
        chk("wrap_cnt", DATA_W'(wrap_cnt), DATA_W'(v.exp_wrap));
        if (!v.lp) begin
            chk("done_busy", DATA_W'(busy), '0);
            chk("done_valid", DATA_W'(m_axis_tvalid), '0);
            enable = 1'b0;
        end else begin
            // Drain: any beat still leaving must continue the sequence.
            for (int d = 0; d < 50; d++) begin
                m_axis_tready = (v.rmode == 2) ? ($urandom_range(0, 1) == 1) : 1'b1;
                chk("drain_no_read", DATA_W'(bram_en), '0);
                if (m_axis_tvalid && m_axis_tready) begin
                    chk("drain_data", m_axis_tdata, pat(s + k % len));
                    k++;
                end
                if (!busy && !m_axis_tvalid) break;
                @(negedge clk);
            end
            chk("drain_idle", DATA_W'({busy, m_axis_tvalid}), '0);
        end
        @(negedge clk);
        @(negedge clk);
        chk("ptr_err_clear", DATA_W'(ptr_err), '0);
    endtask

    vec_t vecs[5];

    initial begin
        int n_en, n_busy, k;
        vec_t v;
        for (int i = 0; i < 4096; i++) mem[i] = pat(i);

        vecs[0] = '{sp: 32'h0,   ep: 32'hC00, lp: 1'b0, rmode: 0, nbeats: 48, exp_wrap: 1,  timing: 1'b1};
        vecs[1] = '{sp: 32'h0,   ep: 32'hC00, lp: 1'b0, rmode: 1, nbeats: 48, exp_wrap: 1,  timing: 1'b0};
        vecs[2] = '{sp: 32'h40,  ep: 32'h100, lp: 1'b1, rmode: 0, nbeats: 30, exp_wrap: 10, timing: 1'b1};
        vecs[3] = '{sp: 32'h80,  ep: 32'hC0,  lp: 1'b1, rmode: 0, nbeats: 5,  exp_wrap: 5,  timing: 1'b1};
        vecs[4] = '{sp: 32'h5F,  ep: 32'h1BF, lp: 1'b0, rmode: 1, nbeats: 5,  exp_wrap: 1,  timing: 1'b0};

        aresetn = 1'b0; enable = 1'b0; loop_en = 1'b0; m_axis_tready = 1'b0;
        start_ptr = '0; stop_ptr = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid", DATA_W'(m_axis_tvalid), '0);
        chk("rst_busy", DATA_W'(busy), '0);
        chk("rst_bram_en", DATA_W'(bram_en), '0);
        chk("rst_wrap", DATA_W'(wrap_cnt), '0);
        chk("rst_ptr_err", DATA_W'(ptr_err), '0);
        aresetn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Empty and inverted ranges raise ptr_err without any reads.
        start_ptr = 32'hC00; stop_ptr = 32'hC00; loop_en = 1'b0; enable = 1'b1;
        n_en = 0; n_busy = 0;
        repeat (8) begin
            @(negedge clk);
            if (bram_en) n_en++;
            if (busy) n_busy++;
        end
        chk("err_flag", DATA_W'(ptr_err), DATA_W'(1));
        chk("err_no_read", DATA_W'(n_en), '0);
        chk("err_not_busy", DATA_W'(n_busy), '0);
        enable = 1'b0; @(negedge clk);
        start_ptr = 32'h100; stop_ptr = 32'h40; enable = 1'b1;
        repeat (3) @(negedge clk);
        chk("err_inverted", DATA_W'({ptr_err, busy}), DATA_W'(2));
        enable = 1'b0; @(negedge clk);
        v = '{sp: 32'hC00, ep: 32'hC40, lp: 1'b0, rmode: 0, nbeats: 1, exp_wrap: 1, timing: 1'b1};
        run_vec(v);

        // Disable while beat 10 is stalled: hold it, then stop cleanly.
        start_ptr = 32'h0; stop_ptr = 32'hC00; loop_en = 1'b0; enable = 1'b1;
        k = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            m_axis_tready = (k < 10);
            if (m_axis_tvalid && k == 10) begin
                enable = 1'b0;
                break;
            end
            if (m_axis_tvalid && m_axis_tready) k++;
        end
        chk("dis_beats_before", DATA_W'(k), DATA_W'(10));
        repeat (3) begin
            @(negedge clk);
            chk("dis_hold_valid", DATA_W'(m_axis_tvalid), DATA_W'(1));
            chk("dis_hold_data", m_axis_tdata, pat(10));
            chk("dis_no_read", DATA_W'(bram_en), '0);
        end
        m_axis_tready = 1'b1;
        @(negedge clk);
        chk("dis_after_accept", DATA_W'({m_axis_tvalid, busy}), '0);
        n_en = 0;
        repeat (5) begin
            @(negedge clk);
            if (bram_en || m_axis_tvalid) n_en++;
        end
        chk("dis_quiet", DATA_W'(n_en), '0);

        // Asynchronous reset between clock edges mid-stream.
        start_ptr = 32'h0; stop_ptr = 32'hC00; loop_en = 1'b1; enable = 1'b1;
        repeat (10) @(negedge clk);
        chk("ar_running", DATA_W'({m_axis_tvalid, busy}), DATA_W'(3));
        #2 aresetn = 1'b0; enable = 1'b0;
        #1;
        chk("ar_valid", DATA_W'(m_axis_tvalid), '0);
        chk("ar_busy", DATA_W'(busy), '0);
        chk("ar_bram_en", DATA_W'(bram_en), '0);
        @(negedge clk); @(negedge clk);
        aresetn = 1'b1;
        n_en = 0;
        repeat (6) begin
            @(negedge clk);
            if (bram_en || m_axis_tvalid || busy) n_en++;
        end
        chk("ar_quiet", DATA_W'(n_en), '0);
        chk("ar_wrap", DATA_W'(wrap_cnt), '0);
        run_vec(vecs[0]);

        // Randomized ranges, modes and backpressure.
        for (int r = 0; r < 20; r++) begin
            int ws, ln;
            ws = int'($urandom_range(0, 200));
            ln = int'($urandom_range(1, 20));
            v.sp = 32'((ws << 6) | int'($urandom_range(0, 63)));
            v.ep = 32'(((ws + ln) << 6) | int'($urandom_range(0, 63)));
            v.lp = ($urandom_range(0, 1) == 1);
            v.rmode = 2;
            v.nbeats = v.lp ? int'($urandom_range(1, 3 * ln + 2)) : ln;
            v.exp_wrap = v.lp ? v.nbeats / ln : 1;
            v.timing = 1'b0;
            run_vec(v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
